// File: rtl/dht11_responder_if.sv
// Parallel side of the DHT11 responder: frame bytes in, status pulses and FSM state out.
interface dht11_responder_if;
    // No valid/ready pair on this bus. The four bytes are level inputs that the
    // responder samples once, when it accepts a host start. busy_out is a level.
    // frame_sent_out and collision_out are single-cycle pulses in the clk_in domain.
    logic [7:0] humidity_int_in;
    logic [7:0] humidity_dec_in;
    logic [7:0] temperature_int_in;
    logic [7:0] temperature_dec_in;
    logic       busy_out;
    logic       frame_sent_out;
    logic       collision_out;
    logic [3:0] state_dbg;

    modport master (
        output humidity_int_in,
        output humidity_dec_in,
        output temperature_int_in,
        output temperature_dec_in,
        input  busy_out,
        input  frame_sent_out,
        input  collision_out,
        input  state_dbg
    );

    modport slave (
        input  humidity_int_in,
        input  humidity_dec_in,
        input  temperature_int_in,
        input  temperature_dec_in,
        output busy_out,
        output frame_sent_out,
        output collision_out,
        output state_dbg
    );
endinterface

// File: rtl/dht11_responder.sv
// DHT11 device-side responder: waits for a host start pulse, acknowledges, then sends a 40-bit frame.
// Optional macro DHT_FAULT_INJECT_EN adds corrupt_cksum_in, which flips checksum bit 0 of a frame.
module dht11_responder #(
    parameter int unsigned CLK_HZ        = 100000000,
    parameter int unsigned START_MIN_US  = 18000,
    parameter int unsigned RESP_DELAY_US = 30,
    parameter int unsigned COLL_US       = 2
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    inout  wire              dht11_io,
`ifdef DHT_FAULT_INJECT_EN
    input  logic             corrupt_cksum_in,
`endif
    dht11_responder_if.slave bus
);

    localparam int unsigned DIV      = CLK_HZ / 1000000;
    localparam int          PRE_W    = $clog2(DIV + 1);
    localparam int unsigned COLL_CYC = COLL_US * DIV;
    localparam int          COLL_W   = $clog2(COLL_CYC + 1);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        HOST_LOW  = 4'd1,
        RESP_WAIT = 4'd2,
        ACK_LOW   = 4'd3,
        ACK_HIGH  = 4'd4,
        BIT_LOW   = 4'd5,
        BIT_HIGH  = 4'd6,
        END_LOW   = 4'd7
    } state_t;

    state_t              state_q;
    state_t              state_d;

    logic                sync_q1;
    logic                sync_q2;
    logic                drv_d1;
    logic                drv_d2;
    logic [PRE_W-1:0]    presc;
    logic [15:0]         us_cnt;
    logic [5:0]          bit_idx;
    logic [39:0]         shreg;
    logic [COLL_W-1:0]   low_cyc;
    logic                frame_sent_q;
    logic                collision_q;

    logic                tick;
    logic                line_low;
    logic                sense_ok;
    logic                released_phase;
    logic                coll_hit;
    logic                phase_done;
    logic                start_ok;
    logic                state_change;
    logic [15:0]         phase_len;
    logic [7:0]          cksum;
    logic [7:0]          cksum_tx;
    logic                drive_low;
    logic                busy;

    assign tick         = (presc == PRE_W'(DIV - 1));
    assign line_low     = ~sync_q2;
    // The synchronizer still shows our own low for two cycles after we release.
    assign sense_ok     = ~drv_d2;
    assign start_ok     = (us_cnt >= 16'(START_MIN_US));
    assign state_change = (state_d != state_q);

    assign released_phase = (state_q == RESP_WAIT) || (state_q == ACK_HIGH) ||
                            (state_q == BIT_HIGH);
    assign coll_hit = released_phase && sense_ok && line_low &&
                      (low_cyc == COLL_W'(COLL_CYC - 1));

    assign cksum = bus.humidity_int_in + bus.humidity_dec_in +
                   bus.temperature_int_in + bus.temperature_dec_in;
`ifdef DHT_FAULT_INJECT_EN
    assign cksum_tx = cksum ^ {7'd0, corrupt_cksum_in};
`else
    assign cksum_tx = cksum;
`endif

    // Length in microseconds of the timed phase the FSM is currently in.
    always_comb begin
        phase_len = 16'd0;
        case (state_q)
            RESP_WAIT: phase_len = 16'(RESP_DELAY_US);
            ACK_LOW:   phase_len = 16'd80;
            ACK_HIGH:  phase_len = 16'd80;
            BIT_LOW:   phase_len = 16'd50;
            BIT_HIGH:  phase_len = shreg[39] ? 16'd70 : 16'd26;
            END_LOW:   phase_len = 16'd50;
            default:   phase_len = 16'd0;
        endcase
    end

    assign phase_done = tick && (us_cnt == (phase_len - 16'd1));

    // State register
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (line_low && sense_ok) state_d = HOST_LOW;
            end
            HOST_LOW: begin
                if (!line_low) state_d = start_ok ? RESP_WAIT : IDLE;
            end
            RESP_WAIT: begin
                if (coll_hit)        state_d = HOST_LOW;
                else if (phase_done) state_d = ACK_LOW;
            end
            ACK_LOW: begin
                if (phase_done) state_d = ACK_HIGH;
            end
            ACK_HIGH: begin
                if (coll_hit)        state_d = HOST_LOW;
                else if (phase_done) state_d = BIT_LOW;
            end
            BIT_LOW: begin
                if (phase_done) state_d = BIT_HIGH;
            end
            BIT_HIGH: begin
                if (coll_hit)        state_d = HOST_LOW;
                else if (phase_done) state_d = (bit_idx == 6'd0) ? END_LOW : BIT_LOW;
            end
            END_LOW: begin
                if (phase_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        drive_low = 1'b0;
        busy      = 1'b0;
        case (state_q)
            RESP_WAIT, ACK_HIGH, BIT_HIGH: busy = 1'b1;
            ACK_LOW, BIT_LOW, END_LOW: begin
                drive_low = 1'b1;
                busy      = 1'b1;
            end
            default: begin
                drive_low = 1'b0;
                busy      = 1'b0;
            end
        endcase
    end

    // Reset releases the line combinationally, without waiting for a clock.
    assign dht11_io = (drive_low && rst_n_in) ? 1'b0 : 1'bz;

    assign bus.busy_out       = busy;
    assign bus.frame_sent_out = frame_sent_q;
    assign bus.collision_out  = collision_q;
    assign bus.state_dbg      = state_q;

    // Datapath: synchronizer, timers, frame shift register, status pulses
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sync_q1      <= 1'b1;
            sync_q2      <= 1'b1;
            drv_d1       <= 1'b0;
            drv_d2       <= 1'b0;
            presc        <= '0;
            us_cnt       <= '0;
            bit_idx      <= '0;
            shreg        <= '0;
            low_cyc      <= '0;
            frame_sent_q <= 1'b0;
            collision_q  <= 1'b0;
        end else begin
            sync_q1      <= dht11_io;
            sync_q2      <= sync_q1;
            drv_d1       <= drive_low;
            drv_d2       <= drv_d1;
            frame_sent_q <= (state_q == END_LOW) && (state_d == IDLE);
            collision_q  <= coll_hit;

            if (state_change || tick) presc <= '0;
            else                      presc <= presc + 1'b1;

            // A collision hands over to HOST_LOW with the low time already seen.
            if (state_change)                     us_cnt <= coll_hit ? 16'(COLL_US) : 16'd0;
            else if (tick && us_cnt != 16'hFFFF)  us_cnt <= us_cnt + 16'd1;

            if (released_phase && sense_ok && line_low && !state_change)
                low_cyc <= low_cyc + 1'b1;
            else
                low_cyc <= '0;

            if (state_q == HOST_LOW && state_d == RESP_WAIT)
                shreg <= {bus.humidity_int_in, bus.humidity_dec_in,
                          bus.temperature_int_in, bus.temperature_dec_in, cksum_tx};

            if (state_q == ACK_HIGH && state_d == BIT_LOW)
                bit_idx <= 6'd39;

            if (state_q == BIT_HIGH && state_d == BIT_LOW) begin
                bit_idx <= bit_idx - 6'd1;
                shreg   <= {shreg[38:0], 1'b0};
            end
        end
    end

endmodule

// File: tb/tb_dht11_responder.sv
// Self-checking bench for dht11_responder: measures every line segment and decodes the frame.
module tb_dht11_responder;
  localparam int unsigned CLK_HZ        = 2000000;
  localparam int          DIV           = CLK_HZ / 1000000;
  localparam int          START_MIN_US  = 200;
  localparam int          RESP_DELAY_US = 30;
  localparam int          COLL_US       = 2;
  localparam int          SYNC_LAT      = 2;
  localparam int          SEG_TIMEOUT   = 1000;

  // clock / reset
  logic clk_in   = 1'b0;
  logic rst_n_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic host_low = 1'b0;
  wire  dht11_line;
  assign dht11_line = host_low ? 1'b0 : 1'bz;
  pullup (dht11_line);

  dht11_responder_if bus ();

  dht11_responder #(
    .CLK_HZ        (CLK_HZ),
    .START_MIN_US  (START_MIN_US),
    .RESP_DELAY_US (RESP_DELAY_US),
    .COLL_US       (COLL_US)
  ) dut (
    .clk_in           (clk_in),
    .rst_n_in         (rst_n_in),
    .dht11_io         (dht11_line),
`ifdef DHT_FAULT_INJECT_EN
    .corrupt_cksum_in (1'b0),
`endif
    .bus              (bus)
  );

  // scoreboard
  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int fs_pulses   = 0;
  int coll_pulses = 0;

  always @(negedge clk_in) begin
    if (bus.frame_sent_out) fs_pulses++;
    if (bus.collision_out)  coll_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
  endtask

  // driver tasks
  task automatic set_bytes(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d);
    int s;
    bus.humidity_int_in    = a;
    bus.humidity_dec_in    = b;
    bus.temperature_int_in = c;
    bus.temperature_dec_in = d;
    s = int'(a) + int'(b) + int'(c) + int'(d);
    exp_q.delete();
    exp_q.push_back(a);
    exp_q.push_back(b);
    exp_q.push_back(c);
    exp_q.push_back(d);
    exp_q.push_back(8'(s % 256));
  endtask

  task automatic set_random_bytes();
    set_bytes(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
              8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
  endtask

  task automatic host_pulse(input int us);
    @(negedge clk_in);
    host_low = 1'b1;
    repeat (us * DIV) @(negedge clk_in);
    host_low = 1'b0;
  endtask

  // Counts negedge samples at level lvl; returns on the first sample of the next segment.
  task automatic seg_len(input logic lvl, input int n0, output int n);
    n = n0;
    forever begin
      @(negedge clk_in);
      if (dht11_line !== lvl) break;
      n++;
      if (n > SEG_TIMEOUT) break;
    end
  endtask

  task automatic seg_check(input string tag, input logic lvl, input int n0, input int exp_n,
                           output int n, output bit ok);
    seg_len(lvl, n0, n);
    check(tag, n, exp_n);
    ok = (n <= SEG_TIMEOUT);
  endtask

  task automatic short_pulse(input int us);
    int lows;
    int busy_seen;
    host_pulse(us);
    lows = 0;
    busy_seen = 0;
    repeat ((RESP_DELAY_US + 200) * DIV) begin
      @(negedge clk_in);
      if (dht11_line !== 1'b1) lows++;
      if (bus.busy_out) busy_seen++;
    end
    check("short_line_low", lows, 0);
    check("short_busy", busy_seen, 0);
    check("short_state_idle", bus.state_dbg, 0);
  endtask

  // mode 0: plain, 1: zero inputs at at_bit, 2: collide at at_bit, 3: reset at at_bit
  task automatic run_frame(input int mode, input int at_bit);
    int n;
    bit ok;
    int fs0;
    int c0;
    logic [39:0] rx;
    logic [39:0] exp_word;
    exp_word = {exp_q[0], exp_q[1], exp_q[2], exp_q[3], exp_q[4]};
    fs0 = fs_pulses;
    c0  = coll_pulses;
    rx  = '0;
    host_pulse(START_MIN_US + 5);
    seg_check("resp_wait", 1'b1, 0, RESP_DELAY_US * DIV + SYNC_LAT, n, ok);
    if (!ok) return;
    check("busy_ack", bus.busy_out, 1);
    seg_check("ack_low", 1'b0, 1, 80 * DIV, n, ok);
    if (!ok) return;
    seg_check("ack_high", 1'b1, 1, 80 * DIV, n, ok);
    if (!ok) return;
    for (int i = 0; i < 40; i++) begin
      if (mode == 1 && i == at_bit) begin
        bus.humidity_int_in    = 8'h00;
        bus.humidity_dec_in    = 8'h00;
        bus.temperature_int_in = 8'h00;
        bus.temperature_dec_in = 8'h00;
      end
      if (mode == 3 && i == at_bit) begin
        repeat (3) @(negedge clk_in);
        #2 rst_n_in = 1'b0;
        #1;
        check("rst_line_released", dht11_line, 1);
        check("rst_busy", bus.busy_out, 0);
        check("rst_frame_sent", bus.frame_sent_out, 0);
        check("rst_collision", bus.collision_out, 0);
        check("rst_state", bus.state_dbg, 0);
        repeat (3) @(negedge clk_in);
        rst_n_in = 1'b1;
        repeat (20) @(negedge clk_in);
        check("post_rst_state", bus.state_dbg, 0);
        check("post_rst_line", dht11_line, 1);
        check("post_rst_busy", bus.busy_out, 0);
        exp_q.delete();
        return;
      end
      seg_check("bit_low", 1'b0, 1, 50 * DIV, n, ok);
      if (!ok) return;
      if (mode == 2 && i == at_bit) begin
        repeat (4) @(negedge clk_in);
        host_low = 1'b1;
        repeat (COLL_US * DIV + 2) @(negedge clk_in);
        host_low = 1'b0;
        repeat (20) @(negedge clk_in);
        check("coll_pulse", coll_pulses - c0, 1);
        check("coll_busy", bus.busy_out, 0);
        check("coll_state_idle", bus.state_dbg, 0);
        check("coll_no_frame", fs_pulses - fs0, 0);
        exp_q.delete();
        return;
      end
      seg_check("bit_high", 1'b1, 1, exp_word[39 - i] ? 70 * DIV : 26 * DIV, n, ok);
      if (!ok) return;
      rx[39 - i] = (n > 48 * DIV);
    end
    seg_check("end_low", 1'b0, 1, 50 * DIV, n, ok);
    if (!ok) return;
    repeat (5) @(negedge clk_in);
    check("frame_sent_pulse", fs_pulses - fs0, 1);
    check("busy_after", bus.busy_out, 0);
    check("no_collision", coll_pulses - c0, 0);
    check("hum_int", rx[39:32], exp_q.pop_front());
    check("hum_dec", rx[31:24], exp_q.pop_front());
    check("tmp_int", rx[23:16], exp_q.pop_front());
    check("tmp_dec", rx[15:8],  exp_q.pop_front());
    check("checksum", rx[7:0],  exp_q.pop_front());
  endtask

  initial begin
    bus.humidity_int_in    = 8'h00;
    bus.humidity_dec_in    = 8'h00;
    bus.temperature_int_in = 8'h00;
    bus.temperature_dec_in = 8'h00;
    repeat (5) @(negedge clk_in);
    check("reset_line", dht11_line, 1);
    check("reset_busy", bus.busy_out, 0);
    check("reset_frame_sent", bus.frame_sent_out, 0);
    check("reset_collision", bus.collision_out, 0);
    check("reset_state", bus.state_dbg, 0);
    rst_n_in = 1'b1;
    repeat (5) @(negedge clk_in);

    set_bytes(8'h2D, 8'h00, 8'h17, 8'h00);
    run_frame(0, 0);

    short_pulse(10);
    short_pulse(START_MIN_US - 5);

    set_bytes(8'hFF, 8'hFF, 8'h01, 8'h02);
    run_frame(1, 20);

    set_random_bytes();
    run_frame(2, int'($urandom_range(5, 30)));
    set_random_bytes();
    run_frame(0, 0);

    set_random_bytes();
    run_frame(3, int'($urandom_range(10, 30)));
    set_random_bytes();
    run_frame(0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
